// File: rtl/run_monitor_pkg.sv
// Shared FSM state type and default parameter values for the run monitor.
package run_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DUMP,
        ST_DONE
    } state_t;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_NUM_REGS  = 16;
    localparam int DEF_IDX_W     = 4;
    localparam int DEF_END_COUNT = 100;
    localparam int DEF_CNT_W     = 32;

endpackage

// File: rtl/run_monitor_dump.sv
// Register-dump streamer: walks the register file once per run and presents
// each register as a valid/ready beat with zero-bubble back-to-back transfer.
module run_monitor_dump
    import run_monitor_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int IDX_W    = DEF_IDX_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] rf_data_i,
    input  logic              dump_ready_i,
    output logic [IDX_W-1:0]  rf_idx_o,
    output logic              dump_valid_o,
    output logic [IDX_W-1:0]  dump_idx_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              last_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    logic accept;

    assign accept = dump_valid_o && dump_ready_i;
    assign last_o = accept && (dump_idx_o == LAST_IDX);

    // rf_idx_o runs one ahead of dump_idx_o so the next beat is loaded on acceptance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rf_idx_o     <= '0;
            dump_valid_o <= 1'b0;
            dump_idx_o   <= '0;
            dump_data_o  <= '0;
        end else if (load_i) begin
            dump_valid_o <= 1'b1;
            dump_idx_o   <= '0;
            dump_data_o  <= rf_data_i;
            rf_idx_o     <= IDX_W'(1);
        end else if (accept) begin
            if (dump_idx_o == LAST_IDX) begin
                dump_valid_o <= 1'b0;
                rf_idx_o     <= '0;
            end else begin
                dump_idx_o  <= rf_idx_o;
                dump_data_o <= rf_data_i;
                rf_idx_o    <= (rf_idx_o == LAST_IDX) ? '0 : rf_idx_o + 1'b1;
            end
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Run monitor: times a run of END_COUNT cycles, then dumps the register file.
// Define RUN_MONITOR_HALT_EN to let halt_i end a run early.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int END_COUNT = DEF_END_COUNT,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              halt_i,
    output logic [IDX_W-1:0]  rf_idx_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [IDX_W-1:0]  dump_idx_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic [CNT_W-1:0]  cycle_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [CNT_W-1:0] END_M1 = CNT_W'(END_COUNT - 1);

    state_t state;
    logic   halt_hit;
    logic   end_hit;
    logic   dump_load;
    logic   dump_last;

`ifdef RUN_MONITOR_HALT_EN
    assign halt_hit = halt_i;
`else
    logic halt_unused;
    assign halt_unused = halt_i;
    assign halt_hit    = 1'b0;
`endif

    assign end_hit   = (cycle_o == END_M1);
    assign dump_load = (state == ST_RUN) && (end_hit || halt_hit);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            cycle_o <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state   <= ST_RUN;
                        cycle_o <= '0;
                        busy_o  <= 1'b1;
                        done_o  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cycle_o != '1) begin
                        cycle_o <= cycle_o + 1'b1;
                    end
                    if (dump_load) begin
                        state <= ST_DUMP;
                    end
                end
                ST_DUMP: begin
                    if (dump_last) begin
                        state  <= ST_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

    run_monitor_dump #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_dump (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (dump_load),
        .rf_data_i    (rf_data_i),
        .dump_ready_i (dump_ready_i),
        .rf_idx_o     (rf_idx_o),
        .dump_valid_o (dump_valid_o),
        .dump_idx_o   (dump_idx_o),
        .dump_data_o  (dump_data_o),
        .last_o       (dump_last)
    );

endmodule

// File: tb/tb_run_monitor.sv
// Directed/random bench for run_monitor: default instance plus a minimal
// END_COUNT=1, NUM_REGS=2 instance, checked against a beat-list model.
`timescale 1ns/1ps
module tb_run_monitor;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int IW = 4;
    localparam int EC = 100;
    localparam int CW = 32;

`ifdef RUN_MONITOR_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, halt, ready;
    logic [IW-1:0] rf_idx, dump_idx;
    logic [DW-1:0] rf_data, dump_data;
    logic          dump_valid, busy, done;
    logic [CW-1:0] cycle;
    logic [DW-1:0] rf [NR];

    assign rf_data = rf[rf_idx];

    run_monitor #(
        .DATA_W(DW), .NUM_REGS(NR), .IDX_W(IW), .END_COUNT(EC), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .halt_i(halt),
        .rf_idx_o(rf_idx), .rf_data_i(rf_data),
        .dump_valid_o(dump_valid), .dump_ready_i(ready),
        .dump_idx_o(dump_idx), .dump_data_o(dump_data),
        .cycle_o(cycle), .busy_o(busy), .done_o(done)
    );

    logic          s_start, s_halt, s_ready;
    logic [0:0]    s_rf_idx, s_dump_idx;
    logic [DW-1:0] s_rf_data, s_dump_data;
    logic          s_valid, s_busy, s_done;
    logic [CW-1:0] s_cycle;
    logic [DW-1:0] s_rf [2];

    assign s_rf_data = s_rf[s_rf_idx];

    run_monitor #(
        .DATA_W(DW), .NUM_REGS(2), .IDX_W(1), .END_COUNT(1), .CNT_W(CW)
    ) dut_s (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .halt_i(s_halt),
        .rf_idx_o(s_rf_idx), .rf_data_i(s_rf_data),
        .dump_valid_o(s_valid), .dump_ready_i(s_ready),
        .dump_idx_o(s_dump_idx), .dump_data_o(s_dump_data),
        .cycle_o(s_cycle), .busy_o(s_busy), .done_o(s_done)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cycle"}, cycle, 0);
        chk({tag, "_valid"}, dump_valid, 0);
        chk({tag, "_idx"}, dump_idx, 0);
        chk({tag, "_data"}, dump_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rf_idx"}, rf_idx, 0);
        chk({tag, "_s_valid"}, s_valid, 0);
        chk({tag, "_s_busy"}, s_busy, 0);
    endtask

    // One run on the default instance. halt_at < 0 disables halt; abort_at >= 0
    // resets mid-dump while that beat is presented.
    task automatic do_run(input int halt_at, input int ready_mode, input int abort_at);
        int            t, exp_entry, acc, dump_cycles;
        logic [CW-1:0] entry_cycle;
        logic          pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        foreach (rf[i]) rf[i] = $urandom;
        exp_entry = (HALT_EN && halt_at >= 0 && halt_at < EC) ? halt_at + 1 : EC;

        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_cycle", cycle, 0);
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);

        t = 0;
        while (!dump_valid && t < 1000) begin
            chk("run_cycle", cycle, t);
            chk("run_rf_idx", rf_idx, 0);
            chk("run_busy", busy, 1);
            halt  = (t == halt_at);
            start = (t == 5);
            tick;
            t++;
        end
        halt  = 1'b0;
        start = 1'b0;
        chk("entry_ticks", t, exp_entry);
        chk("entry_cycle", cycle, exp_entry);
        entry_cycle = cycle;

        acc = 0;
        dump_cycles = 0;
        while (dump_valid && dump_cycles < 200) begin
            if (acc >= NR) begin
                chk("beat_overrun", acc, NR - 1);
                break;
            end
            chk("dump_idx", dump_idx, acc);
            chk("dump_data", dump_data, rf[acc]);
            chk("dump_busy", busy, 1);
            chk("dump_cycle_hold", cycle, entry_cycle);
            if (acc < NR - 1) chk("dump_rf_idx", rf_idx, acc + 1);
            if (acc == abort_at) begin
                start = 1'b0;
                #2 rst = 1'b1;
                #1 check_reset_outputs("abort");
                tick;
                tick;
                rst = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    tick;
                    chk("post_reset_idle_busy", busy, 0);
                    chk("post_reset_idle_cycle", cycle, 0);
                end
                return;
            end
            case (ready_mode)
                0:       ready = 1'b1;
                1:       ready = pat[dump_cycles % 4];
                default: ready = 1'($urandom_range(0, 1));
            endcase
            start = (dump_cycles == 3);
            acc += int'(ready);
            tick;
            dump_cycles++;
        end
        start = 1'b0;
        ready = 1'b1;
        chk("accept_count", acc, NR);
        chk("done_flag", done, 1);
        chk("done_busy", busy, 0);
        chk("done_valid", dump_valid, 0);
        chk("done_cycle", cycle, entry_cycle);
        chk("done_rf_idx", rf_idx, 0);
        if (ready_mode == 0) chk("dump_cycles", dump_cycles, NR);
        tick;
        chk("done_hold", done, 1);
        chk("done_cycle_hold", cycle, entry_cycle);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halt = 1'b0; ready = 1'b1;
        s_start = 1'b0; s_halt = 1'b0; s_ready = 1'b1;
        foreach (rf[i]) rf[i] = '0;
        s_rf[0] = '0; s_rf[1] = '0;
        tick;
        tick;
        check_reset_outputs("reset");
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("idle_no_run", busy, 0);
        end

        do_run(-1, 0, -1);
        do_run(-1, 1, -1);
        do_run(10, 2, -1);
        do_run(int'($urandom_range(0, 120)), 2, -1);
        do_run(-1, 0, 5);
        do_run(-1, 0, -1);

        s_rf[0] = $urandom;
        s_rf[1] = $urandom;
        s_start = 1'b1;
        tick;
        s_start = 1'b0;
        chk("s_start_cycle", s_cycle, 0);
        chk("s_start_valid", s_valid, 0);
        chk("s_start_busy", s_busy, 1);
        tick;
        chk("s_entry_valid", s_valid, 1);
        chk("s_entry_cycle", s_cycle, 1);
        chk("s_beat0_idx", s_dump_idx, 0);
        chk("s_beat0_data", s_dump_data, s_rf[0]);
        tick;
        chk("s_beat1_valid", s_valid, 1);
        chk("s_beat1_idx", s_dump_idx, 1);
        chk("s_beat1_data", s_dump_data, s_rf[1]);
        tick;
        chk("s_done_valid", s_valid, 0);
        chk("s_done_flag", s_done, 1);
        chk("s_done_busy", s_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
